// File: rtl/onehot_pkg.sv
// ---------------------------------------------------------------------------
// onehot_pkg
//
// Shared definitions for the one-hot to binary encoder:
//   ONEHOT_N     default width of the one-hot vector
//   bin_w(n)     width of the binary index needed for an n-bit one-hot bus
//   oh_status_t  classification of a one-hot candidate vector
//                  OH_OK    exactly one bit set
//                  OH_ZERO  no bit set
//                  OH_MULTI two or more bits set
// ---------------------------------------------------------------------------
package onehot_pkg;

    localparam int ONEHOT_N = 8;

    // Width of the encoded index. A 1-bit floor keeps degenerate widths legal.
    function automatic int bin_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [1:0] {
        OH_OK    = 2'd0,
        OH_ZERO  = 2'd1,
        OH_MULTI = 2'd2
    } oh_status_t;

endpackage

// File: rtl/onehot_check.sv
// ---------------------------------------------------------------------------
// onehot_check
//
// Purely combinational classifier and encoder for a one-hot vector.
//
// Build option:
//   ONEHOT_PRIORITY_FALLBACK_EN  when defined, a multi-hot input encodes to
//                                the index of its lowest set bit; otherwise
//                                any malformed input encodes to 0.
//
// Parameters:
//   N       width of the one-hot input (>= 2)
//   W       width of the binary index (bin_w(N))
//
// Ports:
//   one_hot  input  [N-1:0]   candidate vector
//   idx      output [W-1:0]   encoded index
//   status   output           OH_OK / OH_ZERO / OH_MULTI
// ---------------------------------------------------------------------------
module onehot_check
    import onehot_pkg::*;
#(
    parameter int N = ONEHOT_N,
    parameter int W = bin_w(N)
) (
    input  logic [N-1:0] one_hot,
    output logic [W-1:0] idx,
    output oh_status_t   status
);

    logic         is_zero;
    logic         is_multi;
    logic [N-1:0] low_cleared;
    logic [W-1:0] or_idx;
    logic [W-1:0] low_idx;

    // Clearing the lowest set bit leaves something behind only when more
    // than one bit was set.
    assign low_cleared = one_hot & (one_hot - {{(N-1){1'b0}}, 1'b1});
    assign is_zero     = (one_hot == '0);
    assign is_multi    = (low_cleared != '0);

    // OR-reduction encoder: exact for a legal one-hot input and cheap.
    always_comb begin
        or_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (one_hot[k]) begin
                or_idx = or_idx | W'(k);
            end
        end
    end

    // Lowest-set-bit priority encoder: scanning from the top down lets the
    // lowest index overwrite any higher one.
    always_comb begin
        low_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (one_hot[k]) begin
                low_idx = W'(k);
            end
        end
    end

    always_comb begin
        status = OH_OK;
        if (is_zero) begin
            status = OH_ZERO;
        end else if (is_multi) begin
            status = OH_MULTI;
        end
    end

`ifdef ONEHOT_PRIORITY_FALLBACK_EN
    // Zero-hot encodes to 0 via low_idx's default; multi-hot keeps the
    // lowest set bit, which equals or_idx for a legal input.
    assign idx = low_idx;
`else
    assign idx = (status == OH_OK) ? or_idx : '0;
`endif

endmodule

// File: rtl/onehot2bin_encoder.sv
// ---------------------------------------------------------------------------
// onehot2bin_encoder
//
// Converts a one-hot vector to its binary index behind a valid/ready
// handshake with a single registered output stage (1-cycle latency, one
// transfer per cycle when out_ready stays high). Inputs that are not exactly
// one-hot raise out_err and bump a saturating error counter.
//
// Build option:
//   ONEHOT_PRIORITY_FALLBACK_EN  multi-hot inputs encode to the lowest set
//                                bit instead of 0 (handled in onehot_check).
//
// Parameters:
//   N          width of the one-hot input (>= 2)
//   ERR_CNT_W  width of the error counter
//   W          derived index width, bin_w(N)
//
// Ports:
//   clk          input               rising-edge clock
//   rst_n        input               asynchronous active-low reset
//   in_valid     input               one_hot is valid
//   in_ready     output              block can accept this cycle
//   one_hot      input  [N-1:0]      vector to encode
//   out_valid    output              bin / out_err are valid
//   out_ready    input               downstream takes the output
//   bin          output [W-1:0]      encoded index
//   out_err      output              accepted input was not exactly one-hot
//   err_cnt      output [ERR_CNT_W-1:0] saturating malformed-input count
//   err_cnt_clr  input               synchronous clear of err_cnt
// ---------------------------------------------------------------------------
module onehot2bin_encoder
    import onehot_pkg::*;
#(
    parameter int N         = ONEHOT_N,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         one_hot,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [bin_w(N)-1:0]  bin,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_cnt_clr
);

    localparam int W = bin_w(N);

    logic [W-1:0]         idx;
    oh_status_t           status;
    logic                 accept;
    logic                 malformed;

    logic                 vld_p0;
    logic [W-1:0]         bin_p0;
    logic                 err_p0;
    logic [ERR_CNT_W-1:0] cnt_p0;

    // Increment that sticks at the all-ones maximum instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    onehot_check #(
        .N (N),
        .W (W)
    ) u_check (
        .one_hot (one_hot),
        .idx     (idx),
        .status  (status)
    );

    assign malformed = (status != OH_OK);
    assign in_ready  = !vld_p0 || out_ready;
    assign accept    = in_valid && in_ready;

    // ---- stage p0: output register ----
    // Data only loads on accept, so when the stage drains with no new input
    // bin/out_err keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            bin_p0 <= '0;
            err_p0 <= 1'b0;
        end else begin
            if (in_ready) begin
                vld_p0 <= in_valid;
            end
            if (accept) begin
                bin_p0 <= idx;
                err_p0 <= malformed;
            end
        end
    end

    // Counts at accept time, i.e. in step with the result entering p0.
    // Clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0 <= '0;
        end else if (err_cnt_clr) begin
            cnt_p0 <= '0;
        end else if (accept && malformed) begin
            cnt_p0 <= sat_inc(cnt_p0);
        end
    end

    assign out_valid = vld_p0;
    assign bin       = bin_p0;
    assign out_err   = err_p0;
    assign err_cnt   = cnt_p0;

endmodule

// File: tb/tb_onehot2bin_encoder.sv
module tb_onehot2bin_encoder;
    import onehot_pkg::*;

    localparam int N  = 8;
    localparam int W  = 3;
    localparam int CW = 2;

`ifdef ONEHOT_PRIORITY_FALLBACK_EN
    localparam logic [W-1:0] EXP_MULTI_24 = 3'd2;
    localparam logic [W-1:0] EXP_MULTI_C0 = 3'd6;
`else
    localparam logic [W-1:0] EXP_MULTI_24 = 3'd0;
    localparam logic [W-1:0] EXP_MULTI_C0 = 3'd0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  one_hot;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  bin;
    logic          out_err;
    logic [CW-1:0] err_cnt;
    logic          err_cnt_clr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    onehot2bin_encoder #(
        .N         (N),
        .ERR_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .one_hot     (one_hot),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .bin         (bin),
        .out_err     (out_err),
        .err_cnt     (err_cnt),
        .err_cnt_clr (err_cnt_clr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; one_hot = '0; out_ready = 1'b1; err_cnt_clr = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (bin !== 3'd0) begin n_fail++; $display("FAIL reset_bin: got %0d expected 0", bin); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %0b expected 0", out_err); end
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_walk();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) begin
            v = '0;
            v[k] = 1'b1;
            one_hot = v; in_valid = 1'b1; out_ready = 1'b1;
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL walk_valid[%0d]: got %0b expected 1", k, out_valid); end
            n_cmp++; if (bin !== 3'(k)) begin n_fail++; $display("FAIL walk_bin[%0d]: got %0d expected %0d", k, bin, k); end
            n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL walk_err[%0d]: got %0b expected 0", k, out_err); end
        end
        in_valid = 1'b0; one_hot = 'x;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL walk_drain_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (bin !== 3'd7) begin n_fail++; $display("FAIL walk_drain_bin_kept: got %0d expected 7", bin); end
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL walk_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_malformed();
        one_hot = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        n_cmp++; if (bin !== 3'd0) begin n_fail++; $display("FAIL zero_bin: got %0d expected 0", bin); end
        n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL zero_err: got %0b expected 1", out_err); end
        n_cmp++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL zero_err_cnt: got %0d expected 1", err_cnt); end
        one_hot = 8'b0010_0100;
        tick();
        n_cmp++; if (bin !== EXP_MULTI_24) begin n_fail++; $display("FAIL multi_bin: got %0d expected %0d", bin, EXP_MULTI_24); end
        n_cmp++; if (out_err !== 1'b1) begin n_fail++; $display("FAIL multi_err: got %0b expected 1", out_err); end
        n_cmp++; if (err_cnt !== 2'd2) begin n_fail++; $display("FAIL multi_err_cnt: got %0d expected 2", err_cnt); end
        // legal input after an error clears out_err and leaves the count alone
        one_hot = 8'h20;
        tick();
        n_cmp++; if (bin !== 3'd5 || out_err !== 1'b0) begin n_fail++; $display("FAIL legal_after_err: got bin=%0d err=%0b expected bin=5 err=0", bin, out_err); end
        n_cmp++; if (err_cnt !== 2'd2) begin n_fail++; $display("FAIL legal_after_err_cnt: got %0d expected 2", err_cnt); end
        in_valid = 1'b0; err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    task automatic test_backpressure();
        one_hot = 8'h10; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        n_cmp++; if (bin !== 3'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first: got bin=%0d vld=%0b expected bin=4 vld=1", bin, out_valid); end
        one_hot = 8'h40; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", c, in_ready); end
            tick();
            n_cmp++; if (bin !== 3'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d]: got bin=%0d vld=%0b expected bin=4 vld=1", c, bin, out_valid); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %0b expected 1", in_ready); end
        tick();
        n_cmp++; if (bin !== 3'd6 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release: got bin=%0d vld=%0b expected bin=6 vld=1", bin, out_valid); end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %0b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        one_hot = 8'hC0; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (err_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, err_cnt, exp_cnt[i]); end
        end
        n_cmp++; if (bin !== EXP_MULTI_C0 || out_err !== 1'b1) begin n_fail++; $display("FAIL sat_bin: got bin=%0d err=%0b expected bin=%0d err=1", bin, out_err, EXP_MULTI_C0); end
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_clr_wins: got %0d expected 0", err_cnt); end
        n_cmp++; if (out_err !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL sat_clr_accept: got err=%0b vld=%0b expected err=1 vld=1", out_err, out_valid); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        one_hot = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        one_hot = 8'h08;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || bin !== 3'd3 || err_cnt !== 2'd1) begin n_fail++; $display("FAIL arst_pre: got vld=%0b bin=%0d cnt=%0d expected vld=1 bin=3 cnt=1", out_valid, bin, err_cnt); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b expected 0", out_valid); end
        n_cmp++; if (bin !== 3'd0) begin n_fail++; $display("FAIL arst_bin: got %0d expected 0", bin); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL arst_err: got %0b expected 0", out_err); end
        n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL arst_cnt: got %0d expected 0", err_cnt); end
        tick();
        #3;
        rst_n = 1'b1;
        one_hot = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        n_cmp++; if (bin !== 3'd1 || out_valid !== 1'b1 || out_err !== 1'b0) begin n_fail++; $display("FAIL arst_first: got bin=%0d vld=%0b err=%0b expected bin=1 vld=1 err=0", bin, out_valid, out_err); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_walk();
        test_malformed();
        test_backpressure();
        test_saturation();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/onehot2bin_encoder.md
Name: onehot2bin_encoder

Overview:
- Inverse of the team's binary-to-one-hot decoder.
- Accepts a one-hot vector through a valid/ready handshake and returns its binary index from a registered output stage.
- Flags any input that is not exactly one-hot (zero-hot or multi-hot) and keeps a saturating count of those errors.
- Sits at the return end of one-hot select/grant buses: arbiter grants, FSM state vectors, decoder loopback checks.

Parameters:
- N, 8, width of the one-hot input; must be at least 2.
- W, $clog2(N), binary output width; derived localparam, not overridable.
- ERR_CNT_W, 8, width of the error counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  one_hot is valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- one_hot  input  N  vector to encode.
- out_valid  output  1  bin and out_err are valid.
- out_ready  input  1  downstream accepts the output.
- bin  output  W  encoded index.
- out_err  output  1  the accepted input was not exactly one-hot.
- err_cnt  output  ERR_CNT_W  saturating count of accepted malformed inputs.
- err_cnt_clr  input  1  synchronous clear of err_cnt.

Interface decision: one clock, clk; reset is asynchronous and active-low, rst_n.

Behaviour:
- Reset (async assert, sync deassert by upstream): out_valid=0, bin=0, out_err=0, err_cnt=0. Reset mid-transfer discards held output; no replay.
- Output stage: single register. in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready. Full throughput of one input per cycle when out_ready is held high.
- Latency: an input accepted at edge t gives out_valid=1 with its result from edge t onward, i.e. 1 cycle.
- Hold: while out_valid && !out_ready, bin and out_err are stable and in_ready=0.
- On accept with no new input (out_valid && out_ready && !in_valid): out_valid falls to 0. bin and out_err keep their last values.
- Encoding:
  - Exactly one bit k set: bin=k, out_err=0.
  - Zero bits set: bin=0, out_err=1.
  - Two or more bits set: bin=0, out_err=1 (see optional feature).
- Error counter:
  - +1 at each accepted input with out_err=1.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - err_cnt_clr sets it to 0 next edge. Clear wins over a same-cycle increment, so the result is 0.
- in_valid while in_ready=0 has no effect. Upstream holds data (AXI-style); the block never latches it.
- one_hot is X-tolerant only when in_valid=0. No assertion fires on idle X.

Optional Feature:
- Macro: ONEHOT_PRIORITY_FALLBACK_EN.
- Defined: for a multi-hot input, bin = index of the lowest set bit. out_err is still 1 and err_cnt still increments.
- Undefined: multi-hot gives bin=0 as above. Zero-hot gives bin=0 in both builds.

Decomposition:
- Package onehot_pkg holds:
  - default ONEHOT_N=8;
  - function bin_w(n) returning $clog2(n);
  - typedef enum {OH_OK, OH_ZERO, OH_MULTI} oh_status_t. The status is used internally; out_err = (status != OH_OK).
- One combinational sub-module, onehot_check. Inputs: one_hot. Outputs: idx and oh_status_t.
- The top holds only the handshake register and the counter.

Test Plan:
- Walk 8'b0000_0001..8'b1000_0000, out_ready=1, in_valid=1 every cycle -> bin 0..7 on consecutive cycles, 1-cycle latency, out_err=0, err_cnt=0.
- one_hot=8'h00, then 8'b0010_0100 -> both give out_err=1 and err_cnt=2.
  - Without the macro: bin=0, bin=0.
  - With ONEHOT_PRIORITY_FALLBACK_EN: bin=0, bin=2.
- Backpressure: accept 8'h10, hold out_ready=0 for 3 cycles while in_valid=1 with 8'h40.
  - During the hold: bin=4 stable, in_ready=0.
  - out_ready=1: bin=6 on the next cycle.
- Saturation with ERR_CNT_W=2: five malformed inputs -> err_cnt 1,2,3,3,3.
  - err_cnt_clr asserted with a sixth malformed accept -> err_cnt=0.
- Async reset: assert rst_n=0 mid-cycle while out_valid=1 -> out_valid, bin, out_err, err_cnt go to 0 immediately without a clock edge. After release, the first input 8'h02 -> bin=1.
